// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared constants for the stopwatch display path.
//   SEG_0..SEG_9, SEG_BLANK : 7-bit active-low segment codes, bit order {g,f,e,d,c,b,a}
//   SLOT_*                  : scan slot indices; these match the adjust-select encoding
//   DP_SLOT                 : slot whose decimal point separates minutes from seconds
package stopwatch_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] SLOT_SEC_ONES = 2'd0;
  localparam logic [1:0] SLOT_SEC_TENS = 2'd1;
  localparam logic [1:0] SLOT_MIN_ONES = 2'd2;
  localparam logic [1:0] SLOT_MIN_TENS = 2'd3;

  // The dp sits on the minutes-ones digit, so it appears between minutes and seconds.
  localparam logic [1:0] DP_SLOT = SLOT_MIN_ONES;

endpackage

// File: rtl/stopwatch_display_seg7_decode.sv
// seg7_decode
// Combinational BCD to seven-segment decoder with active-low outputs.
//   i_val [3:0] : digit value; 0-9 decode to a glyph, 10-15 decode to blank
//   o_seg [6:0] : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_val)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display
// Time-multiplexes four BCD digits onto a 4-digit common-anode seven-segment
// display, lights the minutes/seconds separator dp, and blinks the selected
// digit while in adjust mode.
//   clk, rst          : clock, asynchronous active-high reset
//   sec_ones/sec_tens : seconds digits (4-bit / 3-bit)
//   min_ones/min_tens : minutes digits (4-bit / 3-bit)
//   adj, sel          : adjust mode and selected digit (0=sec_ones .. 3=min_tens)
//   an  [3:0]         : active-low anode enables, an[i] drives slot i
//   seg [7:0]         : active-low cathodes, seg[7]=dp, seg[6:0]={g,f,e,d,c,b,a}
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_ones,
  input  logic [2:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [2:0] min_tens,
  input  logic       adj,
  input  logic [1:0] sel,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [1:0]         r_scan_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_on;
  logic [3:0]         r_an;
  logic [7:0]         r_seg;

  logic [3:0] w_digit;
  logic [6:0] w_seg7;
  logic       w_blank;
  logic       w_dp_n;
  logic [3:0] w_an_next;
  logic [7:0] w_seg_next;

  // Digit mux; 3-bit tens digits are zero-extended.
  always_comb begin
    w_digit = sec_ones;
    case (r_scan_idx)
      SLOT_SEC_ONES: w_digit = sec_ones;
      SLOT_SEC_TENS: w_digit = {1'b0, sec_tens};
      SLOT_MIN_ONES: w_digit = min_ones;
      SLOT_MIN_TENS: w_digit = {1'b0, min_tens};
      default:       w_digit = sec_ones;
    endcase
  end

  seg7_decode u_decode (
    .i_val (w_digit),
    .o_seg (w_seg7)
  );

  // A blanked slot turns off its anode too, so no digit is lit at all.
  assign w_blank    = adj && !r_blink_on && (r_scan_idx == sel);
  assign w_dp_n     = (r_scan_idx != DP_SLOT);
  assign w_an_next  = w_blank ? 4'b1111 : ~(4'b0001 << r_scan_idx);
  assign w_seg_next = w_blank ? 8'hFF : {w_dp_n, w_seg7};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_scan_idx  <= SLOT_SEC_ONES;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_an        <= 4'b1111;
      r_seg       <= 8'hFF;
    end else begin
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_scan_idx <= r_scan_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end

      // Holding the blink phase outside adjust guarantees a full visible
      // half-period whenever adjust is entered.
      if (!adj) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end

      // an and seg are registered together so the pins change on one edge.
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display
// Scoreboard bench for stopwatch_display with SCAN_DIV=4, BLINK_DIV=16.
// A model process pushes the expected {an,seg} for every active clock edge;
// a monitor pops and compares shortly after the edge.
module tb_stopwatch_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sec_ones = 4'd0;
  logic [2:0] sec_tens = 3'd0;
  logic [3:0] min_ones = 4'd0;
  logic [2:0] min_tens = 3'd0;
  logic       adj = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] an;
  logic [7:0] seg;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];

  // Reference state: edges since reset release, and consecutive prior edges with adj high.
  int n_edges = 0;
  int adj_run = 0;

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  stopwatch_display #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .adj      (adj),
    .sel      (sel),
    .an       (an),
    .seg      (seg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [11:0] model_out();
    int         slot;
    bit         vis_phase;
    logic [3:0] val;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    slot      = (n_edges / SCAN_DIV) % 4;
    vis_phase = ((adj_run / BLINK_DIV) % 2) == 0;
    case (slot)
      0:       val = sec_ones;
      1:       val = {1'b0, sec_tens};
      2:       val = min_ones;
      default: val = {1'b0, min_tens};
    endcase
    if (adj && !vis_phase && (int'(sel) == slot)) begin
      e_an  = 4'b1111;
      e_seg = 8'hFF;
    end else begin
      e_an        = 4'b1111;
      e_an[slot]  = 1'b0;
      e_seg       = (val < 10) ? seg_tbl[val] : 8'hFF;
      if (slot == 2) e_seg[7] = 1'b0;
    end
    return {e_an, e_seg};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        n_edges = 0;
        adj_run = 0;
        exp_q.delete();
      end else begin
        exp_q.push_back(model_out());
        n_edges = n_edges + 1;
        adj_run = adj ? adj_run + 1 : 0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got an=%b seg=%h, want an=%b seg=%h at %0t",
               name, got[11:8], got[7:0], want[11:8], want[7:0], $time);
    end
  endtask

  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", {an, seg}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_digits(input logic [3:0] so, input logic [2:0] st,
                            input logic [3:0] mo, input logic [2:0] mt);
    sec_ones = so;
    sec_tens = st;
    min_ones = mo;
    min_tens = mt;
  endtask

  // Waits (on falling edges) until the anodes show the target; bounded.
  task automatic wait_an(input logic [3:0] target, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (an == target) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total = total + 1;
    if (!hit) begin
      bad = bad + 1;
      $display("FAIL %s: timeout, an=%b never reached %b", name, an, target);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset at time zero, before any clock edge.
    #1 rst = 1'b1;
    #1 check("reset_state", {an, seg}, {4'b1111, 8'hFF});
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_digits(4'd7, 3'd4, 4'd9, 3'd5);
    adj = 1'b0;
    sel = 2'd0;
    rst = 1'b0;

    // Scan sequence across several full rotations.
    repeat (40) @(negedge clk);

    // Invalid digits in slots 0 and 2.
    sec_ones = 4'd12;
    min_ones = 4'd15;
    repeat (20) @(negedge clk);
    set_digits(4'd7, 3'd4, 4'd9, 3'd5);

    // Blink on slot 2 for more than two half-periods.
    adj = 1'b1;
    sel = 2'd2;
    repeat (70) @(negedge clk);

    // Adjust exit while slot 2 is blanked.
    wait_an(4'b1111, "wait_blank");
    adj = 1'b0;
    @(negedge clk);
    total = total + 1;
    if (dut.r_blink_on !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL blink_on_after_exit: got %b want 1", dut.r_blink_on);
    end
    repeat (8) @(negedge clk);

    // Live update in the first cycle of slot 0.
    sec_ones = 4'd3;
    wait_an(4'b0111, "wait_slot3");
    wait_an(4'b1110, "wait_slot0");
    sec_ones = 4'd8;
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of slot 2.
    wait_an(4'b1011, "wait_slot2");
    #1 rst = 1'b1;
    #1 check("reset_mid_slot", {an, seg}, {4'b1111, 8'hFF});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Randomized inputs, including out-of-range digits and adjust toggling.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      sec_ones = 4'($urandom_range(0, 15));
      sec_tens = 3'($urandom_range(0, 7));
      min_ones = 4'($urandom_range(0, 15));
      min_tens = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) adj = ~adj;
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
